// File: rtl/mac_pkg.sv
// mac_pkg: shared defaults for the mac_mul_arb slice.
//   MAC_NUM_REQ      default number of requesters
//   MAC_INPUT_WIDTH  default operand width
//   MAC_MUL_LATENCY  default multiplier latency (cycles)
//   mac_wrap_idx     (base + off) mod n for base, off < n
package mac_pkg;

  localparam int unsigned MAC_NUM_REQ     = 4;
  localparam int unsigned MAC_INPUT_WIDTH = 16;
  localparam int unsigned MAC_MUL_LATENCY = 10;

  function automatic int unsigned mac_wrap_idx(input int unsigned base,
                                               input int unsigned off,
                                               input int unsigned n);
    int unsigned s;
    s = base + off;
    return (s >= n) ? (s - n) : s;
  endfunction

endpackage

// File: rtl/mac_rr_arb.sv
// mac_rr_arb: round-robin grant over NUM_REQ requesters.
//   i_clk, i_rst_n   clock, async active-low reset
//   i_en             grant enable
//   i_req            per-requester request
//   o_grant          one-hot (or zero) grant
//   o_grant_valid    any grant this cycle (equals a handshake)
//   o_grant_id       index of the granted requester
// The pointer moves to the slot after the winner only when a grant is
// given, so an idle or disabled cycle leaves the priority order untouched.
module mac_rr_arb
  import mac_pkg::*;
#(
  parameter int unsigned NUM_REQ = MAC_NUM_REQ
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_en,
  input  logic [NUM_REQ-1:0]         i_req,
  output logic [NUM_REQ-1:0]         o_grant,
  output logic                       o_grant_valid,
  output logic [$clog2(NUM_REQ)-1:0] o_grant_id
);

  localparam int unsigned IDW = $clog2(NUM_REQ);

  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] w_idx;

  always_comb begin
    o_grant       = '0;
    o_grant_valid = 1'b0;
    o_grant_id    = '0;
    w_idx         = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_idx = IDW'(mac_wrap_idx(32'(r_ptr), i, NUM_REQ));
      if (i_en && !o_grant_valid && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        o_grant_valid  = 1'b1;
        o_grant_id     = w_idx;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr <= '0;
    end else if (o_grant_valid) begin
      r_ptr <= IDW'(mac_wrap_idx(32'(o_grant_id), 1, NUM_REQ));
    end
  end

endmodule

// File: rtl/mac_mul_arb.sv
// mac_mul_arb: shares one pipelined multiplier between NUM_REQ requesters.
//   i_clk, i_rst_n           clock, async active-low reset
//   i_en                     grant enable (in-flight work always completes)
//   i_req_valid/a/b          per-requester operands, slice k*INPUT_WIDTH
//   o_req_ready              one-hot accept
//   o_mul_a/b, o_mul_valid   registered multiplier issue
//   i_mul_val, i_mul_valid   multiplier result (MUL_LATENCY after issue)
//   o_rsp_valid, o_rsp_val   registered one-hot response strobe + product
//   o_inflight, o_busy       accepted-but-unreturned count, count != 0
//   o_err                    only with MAC_MUL_ARB_TAG_CHECK_EN: sticky flag
//                            set when i_mul_valid disagrees with the tag valid
module mac_mul_arb
  import mac_pkg::*;
#(
  parameter int unsigned NUM_REQ      = MAC_NUM_REQ,
  parameter int unsigned INPUT_WIDTH  = MAC_INPUT_WIDTH,
  parameter int unsigned OUTPUT_WIDTH = INPUT_WIDTH * 2,
  parameter int unsigned MUL_LATENCY  = MAC_MUL_LATENCY
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic                             i_en,
  input  logic [NUM_REQ-1:0]               i_req_valid,
  input  logic [NUM_REQ*INPUT_WIDTH-1:0]   i_req_a,
  input  logic [NUM_REQ*INPUT_WIDTH-1:0]   i_req_b,
  output logic [NUM_REQ-1:0]               o_req_ready,
  output logic [INPUT_WIDTH-1:0]           o_mul_a,
  output logic [INPUT_WIDTH-1:0]           o_mul_b,
  output logic                             o_mul_valid,
  input  logic [OUTPUT_WIDTH-1:0]          i_mul_val,
  input  logic                             i_mul_valid,
  output logic [NUM_REQ-1:0]               o_rsp_valid,
  output logic [OUTPUT_WIDTH-1:0]          o_rsp_val,
  output logic [$clog2(MUL_LATENCY+3)-1:0] o_inflight,
  output logic                             o_busy
`ifdef MAC_MUL_ARB_TAG_CHECK_EN
  ,
  output logic                             o_err
`endif
);

  localparam int unsigned IDW = $clog2(NUM_REQ);
  localparam int unsigned CW  = $clog2(MUL_LATENCY + 3);

  logic               w_en;
  logic               w_hs;
  logic [IDW-1:0]     w_grant_id;

  logic               r_mul_valid;
  logic [INPUT_WIDTH-1:0] r_mul_a;
  logic [INPUT_WIDTH-1:0] r_mul_b;
  logic [IDW-1:0]     r_mul_id;

  logic [MUL_LATENCY-1:0] r_tag_v;
  logic [IDW-1:0]     r_tag_id [MUL_LATENCY];
  logic               w_tag_v;
  logic [IDW-1:0]     w_tag_id;

  logic [NUM_REQ-1:0]      r_rsp_valid;
  logic [OUTPUT_WIDTH-1:0] r_rsp_val;
  logic [CW-1:0]           r_inflight;

  // Grants are suppressed while reset is held so o_req_ready reads 0 at once.
  assign w_en = i_en & i_rst_n;

  mac_rr_arb #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_en          (w_en),
    .i_req         (i_req_valid),
    .o_grant       (o_req_ready),
    .o_grant_valid (w_hs),
    .o_grant_id    (w_grant_id)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mul_valid <= 1'b0;
      r_mul_a     <= '0;
      r_mul_b     <= '0;
      r_mul_id    <= '0;
    end else begin
      r_mul_valid <= w_hs;
      if (w_hs) begin
        r_mul_a  <= i_req_a[w_grant_id*INPUT_WIDTH +: INPUT_WIDTH];
        r_mul_b  <= i_req_b[w_grant_id*INPUT_WIDTH +: INPUT_WIDTH];
        r_mul_id <= w_grant_id;
      end
    end
  end

  // Tag stage 0 follows the issue register, so the last stage lines up
  // with i_mul_valid MUL_LATENCY cycles after o_mul_valid.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tag_v <= '0;
      for (int unsigned i = 0; i < MUL_LATENCY; i++) begin
        r_tag_id[i] <= '0;
      end
    end else begin
      r_tag_v[0]  <= r_mul_valid;
      r_tag_id[0] <= r_mul_id;
      for (int unsigned i = 1; i < MUL_LATENCY; i++) begin
        r_tag_v[i]  <= r_tag_v[i-1];
        r_tag_id[i] <= r_tag_id[i-1];
      end
    end
  end

  assign w_tag_v  = r_tag_v[MUL_LATENCY-1];
  assign w_tag_id = r_tag_id[MUL_LATENCY-1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rsp_valid <= '0;
      r_rsp_val   <= '0;
    end else begin
      r_rsp_valid <= '0;
      if (w_tag_v) begin
        r_rsp_valid[w_tag_id] <= 1'b1;
        r_rsp_val             <= i_mul_val;
      end
    end
  end

  // The count drops on the same edge that raises o_rsp_valid, so a steady
  // one-per-cycle stream holds it at MUL_LATENCY+1.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_inflight <= '0;
    end else if (w_hs && !w_tag_v) begin
      r_inflight <= r_inflight + CW'(1);
    end else if (!w_hs && w_tag_v) begin
      r_inflight <= r_inflight - CW'(1);
    end
  end

`ifdef MAC_MUL_ARB_TAG_CHECK_EN
  logic r_err;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_err <= 1'b0;
    end else if (i_mul_valid != w_tag_v) begin
      r_err <= 1'b1;
    end
  end

  assign o_err = r_err;
`else
  // Result valid is carried by the tag pipeline; the multiplier's own
  // strobe is not needed in this build.
  logic w_unused_mul_valid;
  assign w_unused_mul_valid = i_mul_valid;
`endif

  assign o_mul_valid = r_mul_valid;
  assign o_mul_a     = r_mul_a;
  assign o_mul_b     = r_mul_b;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_val   = r_rsp_val;
  assign o_inflight  = r_inflight;
  assign o_busy      = (r_inflight != '0);

endmodule

// File: tb/tb_mac_mul_arb.sv
// tb_mac_mul_arb: directed bench for mac_mul_arb with a behavioural
// MUL_LATENCY-deep multiplier and a response scoreboard.
module tb_mac_mul_arb;

  localparam int NR = 4;
  localparam int IW = 16;
  localparam int OW = 32;
  localparam int L  = 10;
  localparam int CW = $clog2(L + 3);

  logic              clk;
  logic              rst_n;
  logic              i_en;
  logic [NR-1:0]     i_req_valid;
  logic [NR*IW-1:0]  i_req_a;
  logic [NR*IW-1:0]  i_req_b;
  logic [NR-1:0]     o_req_ready;
  logic [IW-1:0]     o_mul_a;
  logic [IW-1:0]     o_mul_b;
  logic              o_mul_valid;
  logic [OW-1:0]     i_mul_val;
  logic              i_mul_valid;
  logic [NR-1:0]     o_rsp_valid;
  logic [OW-1:0]     o_rsp_val;
  logic [CW-1:0]     o_inflight;
  logic              o_busy;
`ifdef MAC_MUL_ARB_TAG_CHECK_EN
  logic              o_err;
`endif

  mac_mul_arb #(
    .NUM_REQ      (NR),
    .INPUT_WIDTH  (IW),
    .OUTPUT_WIDTH (OW),
    .MUL_LATENCY  (L)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_en        (i_en),
    .i_req_valid (i_req_valid),
    .i_req_a     (i_req_a),
    .i_req_b     (i_req_b),
    .o_req_ready (o_req_ready),
    .o_mul_a     (o_mul_a),
    .o_mul_b     (o_mul_b),
    .o_mul_valid (o_mul_valid),
    .i_mul_val   (i_mul_val),
    .i_mul_valid (i_mul_valid),
    .o_rsp_valid (o_rsp_valid),
    .o_rsp_val   (o_rsp_val),
    .o_inflight  (o_inflight),
    .o_busy      (o_busy)
`ifdef MAC_MUL_ARB_TAG_CHECK_EN
    ,
    .o_err       (o_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural multiplier: result valid MUL_LATENCY cycles after issue.
  logic          inject;
  logic [L-1:0]  m_v;
  logic [OW-1:0] m_p [L];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_v <= '0;
      for (int i = 0; i < L; i++) m_p[i] <= '0;
    end else begin
      m_v[0] <= o_mul_valid;
      m_p[0] <= OW'(o_mul_a) * OW'(o_mul_b);
      for (int i = 1; i < L; i++) begin
        m_v[i] <= m_v[i-1];
        m_p[i] <= m_p[i-1];
      end
    end
  end

  assign i_mul_valid = m_v[L-1] | inject;
  assign i_mul_val   = m_p[L-1];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int          id;
    logic [OW-1:0] val;
    int          acc;
    int          due;
  } exp_t;

  exp_t q[$];

  int unsigned opa [NR] = '{3, 5, 11, 13};
  int unsigned opb [NR] = '{7, 9, 2, 100};
  logic [IW-1:0] exp_a;
  logic [IW-1:0] exp_b;

  // Scoreboard: responses in order, at accept edge + L + 1, and the
  // in-flight count derived from outstanding accepts.
  always @(negedge clk) begin
    int   cnt;
    exp_t e;
    cnt = 0;
    foreach (q[i]) if (q[i].acc <= cyc && q[i].due > cyc) cnt++;
    chk("inflight", 64'(o_inflight), 64'(cnt));
    chk("busy", 64'(o_busy), 64'(cnt != 0));
    if (o_rsp_valid != '0) begin
      if (q.size() == 0) begin
        chk("spurious_rsp", 64'(o_rsp_valid), 64'd0);
      end else begin
        e = q.pop_front();
        chk("rsp_valid", 64'(o_rsp_valid), 64'd1 << e.id);
        chk("rsp_val", 64'(o_rsp_val), 64'(e.val));
        chk("rsp_cycle", 64'(cyc), 64'(e.due));
      end
    end else if (q.size() != 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      chk("rsp_missing", 64'(o_rsp_valid), 64'd1 << e.id);
    end
  end

  // One cycle: drive, check the combinational grant, then the issue regs.
  task automatic cycle(input bit en, input logic [NR-1:0] v,
                       input logic [NR-1:0] exp_rdy, input string tag);
    int   k;
    exp_t e;
    i_en        = en;
    i_req_valid = v;
    #2;
    chk({tag, "_ready"}, 64'(o_req_ready), 64'(exp_rdy));
    k = -1;
    for (int j = 0; j < NR; j++) if (exp_rdy[j]) k = j;
    if (k >= 0) begin
      e.id  = k;
      e.val = OW'(opa[k]) * OW'(opb[k]);
      e.acc = cyc + 1;
      e.due = cyc + L + 2;
      q.push_back(e);
      exp_a = IW'(opa[k]);
      exp_b = IW'(opb[k]);
    end
    @(posedge clk);
    #1;
    chk({tag, "_mul_valid"}, 64'(o_mul_valid), 64'(k >= 0));
    chk({tag, "_mul_a"}, 64'(o_mul_a), 64'(exp_a));
    chk({tag, "_mul_b"}, 64'(o_mul_b), 64'(exp_b));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, 64'(o_req_ready), 64'd0);
    chk({tag, "_mul_valid"}, 64'(o_mul_valid), 64'd0);
    chk({tag, "_mul_a"}, 64'(o_mul_a), 64'd0);
    chk({tag, "_mul_b"}, 64'(o_mul_b), 64'd0);
    chk({tag, "_rsp_valid"}, 64'(o_rsp_valid), 64'd0);
    chk({tag, "_rsp_val"}, 64'(o_rsp_val), 64'd0);
    chk({tag, "_inflight"}, 64'(o_inflight), 64'd0);
    chk({tag, "_busy"}, 64'(o_busy), 64'd0);
  endtask

  typedef struct {
    bit            en;
    logic [NR-1:0] v;
    logic [NR-1:0] rdy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input bit en, input logic [NR-1:0] v, input logic [NR-1:0] rdy);
    vec_t r;
    r.en = en; r.v = v; r.rdy = rdy;
    return r;
  endfunction

  initial begin
    // Pointer starts at 0 after reset; each row's grant is hand-derived.
    tbl.push_back(mk(1, 4'b0000, 4'b0000));
    tbl.push_back(mk(1, 4'b0001, 4'b0001));  // single req0 3*7, ptr->1
    tbl.push_back(mk(1, 4'b1000, 4'b1000));  // ptr wraps 3->0
    tbl.push_back(mk(1, 4'b1111, 4'b0001));  // eight-cycle rotation
    tbl.push_back(mk(1, 4'b1111, 4'b0010));
    tbl.push_back(mk(1, 4'b1111, 4'b0100));
    tbl.push_back(mk(1, 4'b1111, 4'b1000));
    tbl.push_back(mk(1, 4'b1111, 4'b0001));
    tbl.push_back(mk(1, 4'b1111, 4'b0010));
    tbl.push_back(mk(1, 4'b1111, 4'b0100));
    tbl.push_back(mk(1, 4'b1111, 4'b1000));  // ptr 0
    tbl.push_back(mk(0, 4'b1111, 4'b0000));  // disabled, ptr holds
    tbl.push_back(mk(0, 4'b0001, 4'b0000));
    tbl.push_back(mk(1, 4'b0100, 4'b0100));  // req2 back-to-back, ptr 3
    tbl.push_back(mk(1, 4'b0100, 4'b0100));
    tbl.push_back(mk(1, 4'b0110, 4'b0010));  // req1 joins: 1,2,1,2
    tbl.push_back(mk(1, 4'b0110, 4'b0100));
    tbl.push_back(mk(1, 4'b0110, 4'b0010));
    tbl.push_back(mk(1, 4'b0110, 4'b0100));  // ptr 3
    tbl.push_back(mk(1, 4'b1001, 4'b1000));
    tbl.push_back(mk(1, 4'b1001, 4'b0001));  // ptr 1
    tbl.push_back(mk(1, 4'b0011, 4'b0010));  // ptr 2
    tbl.push_back(mk(1, 4'b0011, 4'b0001));  // ptr 1
    tbl.push_back(mk(1, 4'b0000, 4'b0000));

    rst_n       = 1'b0;
    inject      = 1'b0;
    i_en        = 1'b0;
    i_req_valid = '0;
    exp_a       = '0;
    exp_b       = '0;
    for (int k = 0; k < NR; k++) begin
      i_req_a[k*IW +: IW] = IW'(opa[k]);
      i_req_b[k*IW +: IW] = IW'(opb[k]);
    end

    repeat (2) @(posedge clk);
    #1;
    i_en        = 1'b1;
    i_req_valid = 4'b1111;
    #1;
    chk_all_zero("reset");
`ifdef MAC_MUL_ARB_TAG_CHECK_EN
    chk("reset_err", 64'(o_err), 64'd0);
`endif
    i_req_valid = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].en, tbl[i].v, tbl[i].rdy, $sformatf("vec%0d", i));
    end
    repeat (L + 3) cycle(1, 4'b0000, 4'b0000, "drain1");

    // Steady state: one accept per cycle, count settles at L+1.
    for (int i = 0; i < 20; i++) cycle(1, 4'b0001, 4'b0001, "steady");
    chk("steady_inflight", 64'(o_inflight), 64'(L + 1));
    chk("steady_busy", 64'(o_busy), 64'd1);
    repeat (L + 3) cycle(1, 4'b0000, 4'b0000, "drain2");
    chk("drained_inflight", 64'(o_inflight), 64'd0);
    chk("drained_busy", 64'(o_busy), 64'd0);

    // Reset with five in flight (ptr at 1 after the req0-only stream).
    cycle(1, 4'b1111, 4'b0010, "pre_rst");
    cycle(1, 4'b1111, 4'b0100, "pre_rst");
    cycle(1, 4'b1111, 4'b1000, "pre_rst");
    cycle(1, 4'b1111, 4'b0001, "pre_rst");
    cycle(1, 4'b1111, 4'b0010, "pre_rst");
    #1;
    rst_n = 1'b0;
    q.delete();
    exp_a = '0;
    exp_b = '0;
    #1;
    chk_all_zero("midrst");
    @(posedge clk);
    #1;
    i_req_valid = '0;
    rst_n       = 1'b1;
    repeat (L + 4) cycle(1, 4'b0000, 4'b0000, "post_rst_idle");
    cycle(1, 4'b1111, 4'b0001, "post_rst_first");
    repeat (L + 3) cycle(1, 4'b0000, 4'b0000, "drain3");

`ifdef MAC_MUL_ARB_TAG_CHECK_EN
    chk("err_clean", 64'(o_err), 64'd0);
`endif
    // Spurious multiplier strobe with no tag: must not produce a response.
    inject = 1'b1;
    @(posedge clk);
    #1;
    inject = 1'b0;
`ifdef MAC_MUL_ARB_TAG_CHECK_EN
    chk("err_set", 64'(o_err), 64'd1);
`endif
    repeat (3) cycle(1, 4'b0000, 4'b0000, "after_inject");
`ifdef MAC_MUL_ARB_TAG_CHECK_EN
    chk("err_sticky", 64'(o_err), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("err_reset", 64'(o_err), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
`endif
    repeat (2) @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
